exe_div_unit: RTL and testbench
===============================

// Module: exe_div_unit
// PURPOSE
//  Iterative 32-bit signed/unsigned divider in the EXE stage, directly downstream of the ID/EXE register.
//  Consumes the EXE-side ALU op and operands and produces {HI=remainder, LO=quotient} for MIPS DIV/DIVU.
//  Holds the pipeline through its stall request so the ID/EXE register keeps the op until the result is ready.
// PARAMETERS
//  OP_DIV   8'h1A  exe_alu_op_i encoding for DIV (signed)
//  OP_DIVU  8'h1B  exe_alu_op_i encoding for DIVU (unsigned)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, synchronous, active-high
//  flush_i       in   1   pipeline flush (exception/eret); aborts any divide
//  exe_alu_op_i  in   8   ALU op from ID/EXE register
//  exe_reg1_i    in   32  dividend (rs)
//  exe_reg2_i    in   32  divisor (rt)
//  stall_req_o   out  1   request to pipeline control to stall IF..EXE (combinational)
//  div_ready_o   out  1   one-cycle pulse: div_result_o valid
//  div_result_o  out  64  {remainder[63:32], quotient[31:0]}
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, div_ready_o=0, div_result_o=64'h0, internal dividend/divisor/partial rem=0.
//  - States: IDLE, BUSY, DONE. is_div = (exe_alu_op_i==OP_DIV)||(exe_alu_op_i==OP_DIVU).
//  - IDLE: if is_div && !flush_i: latch |dividend|, |divisor| (abs only for OP_DIV), signs, op;
//    divisor==0 -> DONE, result {exe_reg1_i, 32'hFFFF_FFFF}; else -> BUSY, cnt=0.
//  - BUSY: one restoring step/cycle: rem={rem[31:0],q[31]} - divisor; if >=0 keep and shift in 1, else
//    restore and shift in 0; cnt++; after step cnt==31 (32 steps) apply sign fix-up, -> DONE.
//  - Sign fix-up (OP_DIV only): quotient negated if dividend/divisor signs differ; remainder takes dividend
//    sign. 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0 (32-bit wrap, no trap).
//  - DONE: div_ready_o=1 for exactly this cycle, div_result_o registered and stable; -> IDLE next edge.
//    The op still sits in ID/EXE during DONE; it must NOT restart (DONE never samples is_div).
//  - stall_req_o = !flush_i && ((IDLE && is_div) || BUSY). Deasserted in DONE so the pipeline advances
//    on the same edge DONE->IDLE. Latency: 34 cycles EXE occupancy (IDLE+32 BUSY+DONE); div-by-0: 2.
//  - flush_i in any state: -> IDLE next edge, div_ready_o=0, cnt=0, stall_req_o=0 immediately; div_result_o
//    keeps last value. flush_i in IDLE with is_div: no start.
//  - rst mid-operation: identical to reset values next edge; no partial result visible.
//  - div_result_o holds last completed result until next DONE; only meaningful when div_ready_o=1.
//  - All arithmetic 33-bit for subtract (borrow in bit 32); abs(0x8000_0000) = 0x8000_0000 unsigned.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in IDLE, if |dividend| < |divisor| (divisor!=0) go straight to DONE with
//    quotient 0, remainder = exe_reg1_i (signed semantics preserved); latency 2 cycles.
//  Not defined: every non-zero divisor takes the full 32 BUSY cycles (34-cycle occupancy).
// TESTING
//  - DIVU 100/7 -> stall_req_o high 33 cycles, div_ready_o pulse, result {32'd2, 32'd14}.
//  - DIV -7/2 (0xFFFF_FFF9, 2) -> result {0xFFFF_FFFF, 0xFFFF_FFFD}; DIV 0x8000_0000/-1 -> {0, 0x8000_0000}.
//  - DIVU 5/0 -> 2-cycle occupancy, result {32'd5, 32'hFFFF_FFFF}, no BUSY state entered.
//  - flush_i at BUSY cnt=10 -> stall_req_o 0 same cycle, IDLE next edge, no div_ready_o; next DIV runs cleanly.
//  - Op held through DONE, then back-to-back DIVU 9/3 next cycle -> two separate pulses, second {0, 3}.
//  - DIV_EARLY_OUT_EN: DIVU 3/10 -> ready 2nd cycle, {32'd3, 32'd0}; without macro -> 34 cycles, same result.

Source files
------------

// File: rtl/exe_div_unit.sv
// exe_div_unit
//   Iterative 32-bit signed/unsigned divider for the EXE stage. It sits directly
//   after the ID/EXE register and produces {HI=remainder, LO=quotient} for
//   MIPS DIV/DIVU. It uses one restoring step per cycle. While the divide runs,
//   it holds IF..EXE through stall_req_o so that ID/EXE keeps the op stable.
//
// Parameters
//   OP_DIV        ALU op encoding for DIV  (signed)
//   OP_DIVU       ALU op encoding for DIVU (unsigned)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   flush_i       pipeline flush; aborts any divide in progress
//   exe_alu_op_i  ALU op from ID/EXE
//   exe_reg1_i    dividend (rs)
//   exe_reg2_i    divisor  (rt)
//   stall_req_o   combinational stall request to pipeline control
//   div_ready_o   one-cycle pulse, div_result_o valid
//   div_result_o  {remainder[63:32], quotient[31:0]}, held until next result
//
// Configuration
//   DIV_EARLY_OUT_EN  when defined, a divide with |dividend| < |divisor| skips
//                     the iteration and finishes in 2 cycles (quotient 0,
//                     remainder = original dividend).

module exe_div_unit #(
  parameter logic [7:0] OP_DIV  = 8'h1A,
  parameter logic [7:0] OP_DIVU = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  exe_alu_op_i,
  input  logic [31:0] exe_reg1_i,
  input  logic [31:0] exe_reg2_i,
  output logic        stall_req_o,
  output logic        div_ready_o,
  output logic [63:0] div_result_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  cnt;
  logic [31:0] quot;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic        op_signed;
  logic        dividend_neg;
  logic        divisor_neg;

  logic        is_div;
  logic        is_signed;
  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  logic        divisor_zero;
  logic        early_out;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        step_ge;
  logic [31:0] rem_step;
  logic [31:0] quot_step;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // Decode the op and form operand magnitudes for the iteration.
  // abs(0x8000_0000) wraps to 0x8000_0000, which is the correct unsigned magnitude.
  always_comb begin
    is_div       = (exe_alu_op_i == OP_DIV) || (exe_alu_op_i == OP_DIVU);
    is_signed    = (exe_alu_op_i == OP_DIV);
    abs_dividend = (is_signed && exe_reg1_i[31]) ? -exe_reg1_i : exe_reg1_i;
    abs_divisor  = (is_signed && exe_reg2_i[31]) ? -exe_reg2_i : exe_reg2_i;
    divisor_zero = (exe_reg2_i == 32'h0);
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (abs_dividend < abs_divisor);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step. The partial remainder always stays below the divisor,
  // so the shifted value is below 2*divisor. A 33-bit difference is therefore
  // enough, and bit 32 is the borrow: it is set exactly when the trial
  // subtract must be undone.
  always_comb begin
    shifted   = {rem, quot[31]};
    diff      = shifted - {1'b0, divisor};
    step_ge   = ~diff[32];
    rem_step  = step_ge ? diff[31:0] : shifted[31:0];
    quot_step = {quot[30:0], step_ge};
    quot_fix  = (op_signed && (dividend_neg ^ divisor_neg)) ? -quot_step : quot_step;
    rem_fix   = (op_signed && dividend_neg) ? -rem_step : rem_step;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. DONE never looks at is_div, because the finished op is
  // still sitting in ID/EXE during that cycle.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (is_div) state_next = (divisor_zero || early_out) ? DONE : BUSY;
        BUSY:    if (cnt == 5'd31) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs. The stall drops in DONE so that the pipeline advances on the same
  // edge that returns the divider to IDLE.
  always_comb begin
    stall_req_o = !flush_i && (((state == IDLE) && is_div) || (state == BUSY));
    div_ready_o = (state == DONE) && !flush_i;
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 5'd0;
      quot         <= 32'h0;
      divisor      <= 32'h0;
      rem          <= 32'h0;
      op_signed    <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      div_result_o <= 64'h0;
    end else if (flush_i) begin
      cnt <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_div) begin
            op_signed    <= is_signed;
            dividend_neg <= is_signed && exe_reg1_i[31];
            divisor_neg  <= is_signed && exe_reg2_i[31];
            quot         <= abs_dividend;
            divisor      <= abs_divisor;
            rem          <= 32'h0;
            cnt          <= 5'd0;
            if (divisor_zero)   div_result_o <= {exe_reg1_i, 32'hFFFF_FFFF};
            else if (early_out) div_result_o <= {exe_reg1_i, 32'h0};
          end
        end
        BUSY: begin
          quot <= quot_step;
          rem  <= rem_step;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'd31) div_result_o <= {rem_fix, quot_fix};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// tb_exe_div_unit
//   Directed bench for exe_div_unit. Each divide pushes its reference result
//   onto a scoreboard queue. The entry is popped and compared when div_ready_o
//   pulses. The bench also checks occupancy, stall length, flush and reset.

module tb_exe_div_unit;

  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_NOP  = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [7:0]  exe_alu_op_i;
  logic [31:0] exe_reg1_i;
  logic [31:0] exe_reg2_i;
  logic        stall_req_o;
  logic        div_ready_o;
  logic [63:0] div_result_o;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] expQ[$];
  logic [63:0] lastResult  = 64'h0;

  exe_div_unit #(.OP_DIV(OP_DIV), .OP_DIVU(OP_DIVU)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .exe_alu_op_i (exe_alu_op_i),
    .exe_reg1_i   (exe_reg1_i),
    .exe_reg2_i   (exe_reg2_i),
    .stall_req_o  (stall_req_o),
    .div_ready_o  (div_ready_o),
    .div_result_o (div_result_o)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the DUT wedges somewhere a bounded wait does not cover.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model built from the language's own division operators.
  function automatic logic [63:0] modelDiv(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (op == OP_DIVU) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end
    return {r, q};
  endfunction

  // Expected EXE occupancy in cycles, counted from the op entering to the ready pulse inclusive.
  function automatic int modelCycles(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ax;
    logic [31:0] ay;
    ax = (op == OP_DIV && x[31]) ? -x : x;
    ay = (op == OP_DIV && y[31]) ? -y : y;
    if (y == 32'h0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ax < ay) return 2;
`endif
    if (ax == ay) return 34;
    return 34;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Drives one divide at a negedge and waits for the ready pulse. The task
  // returns at the negedge after DONE. When chain is set, the op is left on
  // the inputs for the caller to replace at once (back-to-back).
  task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [31:0] x,
                               input logic [31:0] y, input bit chain);
    logic [63:0] expv;
    int          expCyc;
    int          cyc      = 0;
    int          stallCyc = 0;
    bit          seen     = 1'b0;
    expv   = modelDiv(op, x, y);
    expCyc = modelCycles(op, x, y);
    expQ.push_back(expv);
    exe_alu_op_i = op;
    exe_reg1_i   = x;
    exe_reg2_i   = y;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      cyc++;
      if (div_ready_o) begin
        seen = 1'b1;
        checkOutput({tag, " stall in DONE"}, 64'(stall_req_o), 64'd0);
        checkOutput({tag, " result"}, div_result_o, expQ.pop_front());
        lastResult = expv;
      end else if (stall_req_o) begin
        stallCyc++;
      end
      @(negedge clk);
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s timeout: no div_ready_o within 100 cycles, required %0d", tag, expCyc);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else begin
      checkOutput({tag, " occupancy"}, 64'(cyc), 64'(expCyc));
      checkOutput({tag, " stall cycles"}, 64'(stallCyc), 64'(expCyc - 1));
    end
    if (!chain) begin
      exe_alu_op_i = OP_NOP;
      #1;
      checkOutput({tag, " ready after"}, 64'(div_ready_o), 64'd0);
      checkOutput({tag, " stall after"}, 64'(stall_req_o), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;

    // Reset while a DIV is presented: nothing may start or pulse.
    rst          = 1'b1;
    flush_i      = 1'b0;
    exe_alu_op_i = OP_DIV;
    exe_reg1_i   = 32'd100;
    exe_reg2_i   = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset ready", 64'(div_ready_o), 64'd0);
    checkOutput("reset result", div_result_o, 64'h0);
    exe_alu_op_i = OP_NOP;
    #1;
    checkOutput("reset stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Main function, including a back-to-back pair after DONE.
    applyStimulus("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b1);
    applyStimulus("divu 9/3 b2b", OP_DIVU, 32'd9, 32'd3, 1'b0);
    applyStimulus("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("divu 5/0", OP_DIVU, 32'd5, 32'd0, 1'b0);
    applyStimulus("div -20/0", OP_DIV, 32'hFFFF_FFEC, 32'd0, 1'b0);
    applyStimulus("divu 3/10", OP_DIVU, 32'd3, 32'd10, 1'b0);
    applyStimulus("div -3/10", OP_DIV, 32'hFFFF_FFFD, 32'd10, 1'b0);
    applyStimulus("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("div -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    applyStimulus("divu big/big", OP_DIVU, 32'h8000_0001, 32'h8000_0000, 1'b0);
    applyStimulus("divu max/max-1", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    applyStimulus("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // A flush at BUSY cnt=10 drops the stall at once and returns to IDLE with no
    // pulse. A flush held in IDLE with the op present must not start a divide.
    exe_alu_op_i = OP_DIV;
    exe_reg1_i   = 32'd1000;
    exe_reg2_i   = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    checkOutput("flush pre stall", 64'(stall_req_o), 64'd1);
    flush_i = 1'b1;
    #1;
    checkOutput("flush stall now", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("flush idle ready", 64'(div_ready_o), 64'd0);
    checkOutput("flush idle stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    flush_i      = 1'b0;
    exe_alu_op_i = OP_NOP;
    #1;
    checkOutput("flush no start", 64'(div_ready_o), 64'd0);
    checkOutput("flush result kept", div_result_o, lastResult);
    @(negedge clk);
    applyStimulus("div after flush", OP_DIV, 32'hFFFF_FC18, 32'd3, 1'b0);

    // Reset mid-operation returns to reset values with no partial result.
    exe_alu_op_i = OP_DIVU;
    exe_reg1_i   = 32'd50;
    exe_reg2_i   = 32'd5;
    repeat (6) @(negedge clk);
    rst          = 1'b1;
    exe_alu_op_i = OP_NOP;
    @(negedge clk);
    #1;
    checkOutput("midrst ready", 64'(div_ready_o), 64'd0);
    checkOutput("midrst result", div_result_o, 64'h0);
    checkOutput("midrst stall", 64'(stall_req_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus("divu after rst", OP_DIVU, 32'd100, 32'd7, 1'b0);

    // A few pseudo-random operands of varied magnitude.
    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 30);
      applyStimulus((i % 2 == 0) ? "rand divu" : "rand div", (i % 2 == 0) ? OP_DIVU : OP_DIV, rx, ry, 1'b0);
    end

    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard: %0d entries left, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
